regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter NRD, default 2, number of read ports (1..4).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 we0  in  1  write enable, write port 0.
REQ-007 waddr0  in  ADDR_W  write address, port 0.
REQ-008 wdata0  in  DATA_W  write data, port 0.
REQ-009 we1 / waddr1 / wdata1  in  1 / ADDR_W / DATA_W  write port 1, same meaning as port 0.
REQ-010 re  in  NRD  per-port read enable.
REQ-011 raddr  in  NRD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-012 rdata  out  NRD*DATA_W  packed read data, port k at bits [k*DATA_W +: DATA_W].
REQ-013 issue_vld  in  1  marks issue_addr as pending (scoreboard set).
REQ-014 issue_addr  in  ADDR_W  register pending writeback.
REQ-015 busy  out  NRD  per-port scoreboard status of raddr.
REQ-016 init_done  out  1  high once the register array has been cleared after reset.

Function
REQ-017 Two states, INIT and RUN; INIT entered on rst, sweeps counter 0..DEPTH-1 writing 0 to one register per cycle, then goes to RUN; RUN held until next rst.
REQ-018 INIT lasts exactly DEPTH cycles after the first cycle with rst low; init_done SHALL rise on the following edge and stay high in RUN.
REQ-019 During INIT: we0/we1/issue_vld ignored, all rdata = 0, all busy = 0.
REQ-020 Register 0 reads 0 always; writes and issues to address 0 dropped; busy never set for address 0.
REQ-021 Writes in RUN: registered on clk edge; both ports may write different addresses in one cycle; same address → port 1 data stored.
REQ-022 Read port k combinational: re[k]=0 → 0; raddr 0 → 0; raddr matches an enabled write this cycle → that wdata (port 1 over port 0); else stored value.
REQ-023 Scoreboard: one busy bit per register, cleared in INIT; issue_vld sets bit issue_addr at next edge.
REQ-024 Write (either port) to an address clears its busy bit at next edge.
REQ-025 Issue and write to same address in same cycle → bit ends set (new issue wins).
REQ-026 busy[k] = re[k] && raddr[k]!=0 && busy bit set && no enabled write to raddr[k] this cycle (combinational, consistent with forwarding).
REQ-027 Read ports independent; identical addresses on multiple ports return identical data.

Reset
REQ-028 rst high: state := INIT, counter := 0, init_done := 0, all busy bits := 0; rdata and busy outputs 0 while rst high.
REQ-029 rst asserted mid-INIT or mid-RUN restarts INIT from counter 0; any write in that cycle discarded.
REQ-030 Register contents undefined only until INIT finishes; after init_done every register reads 0 until written.

Verification
REQ-031 rst 1 cycle, release, idle → init_done rises after exactly 32 cycles (defaults); reads of all 32 addresses return 0.
REQ-032 RUN: we0 waddr0=5 wdata0=0xDEADBEEF; same cycle raddr[0]=5 re=1 → rdata[0]=0xDEADBEEF (bypass); next cycle stored value read.
REQ-033 we0 and we1 both to addr 7 with 0x11 / 0x22 → addr 7 reads 0x22; write 0x55 to addr 0 → addr 0 reads 0.
REQ-034 issue_vld addr 3 → busy[0]=1 for raddr 3 next cycle; we1 addr 3 → busy[0]=0 in write cycle and after; simultaneous issue+write addr 3 → busy stays 1.
REQ-035 Write 0xAA to addr 9 in RUN, assert rst for 1 cycle mid-INIT restart at counter 10 → init_done low for full 32 cycles again; addr 9 reads 0 after.
REQ-036 re=0 on port 1 with raddr 9 holding 0xAA → rdata port 1 = 0, busy[1]=0.

Source files
------------

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - write/read/scoreboard bundle for regfile_sb
//
// Groups every regfile_sb signal except clk and rst.
//   we0/waddr0/wdata0, we1/waddr1/wdata1 : two write ports
//   re/raddr/rdata  : NRD packed read ports, port k at [k*W +: W]
//   issue_vld/issue_addr : marks a register as pending writeback
//   busy            : per-read-port pending status
//   init_done       : array cleared after reset
// master drives requests (bench / pipeline); slave is the register file.

interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic                    we0;
    logic [ADDR_W-1:0]       waddr0;
    logic [DATA_W-1:0]       wdata0;
    logic                    we1;
    logic [ADDR_W-1:0]       waddr1;
    logic [DATA_W-1:0]       wdata1;
    logic [NRD-1:0]          re;
    logic [NRD*ADDR_W-1:0]   raddr;
    logic [NRD*DATA_W-1:0]   rdata;
    logic                    issue_vld;
    logic [ADDR_W-1:0]       issue_addr;
    logic [NRD-1:0]          busy;
    logic                    init_done;

    modport master (
        output we0, waddr0, wdata0, we1, waddr1, wdata1,
        output re, raddr, issue_vld, issue_addr,
        input  rdata, busy, init_done
    );

    modport slave (
        input  we0, waddr0, wdata0, we1, waddr1, wdata1,
        input  re, raddr, issue_vld, issue_addr,
        output rdata, busy, init_done
    );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - 2-write / NRD-read register file with busy scoreboard
//
// Ports:
//   clk  : single clock, all state on rising edge
//   rst  : synchronous active-high reset, restarts the clearing sweep
//   bus  : regfile_sb_if slave modport (write ports, read ports,
//          issue, busy, init_done)
// After reset the array is swept to zero one register per cycle (INIT);
// then RUN serves reads with write-to-read forwarding and a per-register
// busy bit set by issue and cleared by writeback.

module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic          clk,
    input  logic          rst,
    regfile_sb_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  cnt;
    logic               init_done_q;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]   sb;
    logic               run;
    logic               w0;
    logic               w1;
    logic               iss;

    always_comb begin
        state_next = state;
        run        = 1'b0;
        case (state)
            ST_INIT: begin
                if (cnt == ADDR_W'(DEPTH - 1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // Outputs and updates are suppressed during the reset cycle.
                run = !rst;
            end
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_INIT;
            cnt         <= '0;
            init_done_q <= 1'b0;
        end else begin
            state       <= state_next;
            init_done_q <= (state_next == ST_RUN);
            if (state == ST_INIT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.init_done = init_done_q;

    // Address 0 is hardwired to zero, so its writes and issues are dropped.
    assign w0  = run && bus.we0 && (bus.waddr0 != '0);
    assign w1  = run && bus.we1 && (bus.waddr1 != '0);
    assign iss = run && bus.issue_vld && (bus.issue_addr != '0);

    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_INIT) begin
            mem[cnt] <= '0;
        end
        if (w0) begin
            mem[bus.waddr0] <= bus.wdata0;
        end
        if (w1) begin
            mem[bus.waddr1] <= bus.wdata1;
        end
    end

    // Issue is applied after the writeback clear so a new issue wins.
    always_ff @(posedge clk) begin
        if (rst || state == ST_INIT) begin
            sb <= '0;
        end else begin
            if (w0) begin
                sb[bus.waddr0] <= 1'b0;
            end
            if (w1) begin
                sb[bus.waddr1] <= 1'b0;
            end
            if (iss) begin
                sb[bus.issue_addr] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              en;
        logic              hit0;
        logic              hit1;

        assign ra   = bus.raddr[k*ADDR_W +: ADDR_W];
        assign en   = run && bus.re[k] && (ra != '0);
        assign hit0 = w0 && (bus.waddr0 == ra);
        assign hit1 = w1 && (bus.waddr1 == ra);

        assign bus.rdata[k*DATA_W +: DATA_W] = !en  ? '0 :
                                               hit1 ? bus.wdata1 :
                                               hit0 ? bus.wdata0 : mem[ra];
        // A write in flight this cycle forwards its data, so it is not busy.
        assign bus.busy[k] = en && sb[ra] && !hit0 && !hit1;
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb

module tb_regfile_sb;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] m_mem [DEPTH];
    bit            m_busy [DEPTH];

    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) bus ();

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic idle();
        bus.we0 = 0; bus.waddr0 = '0; bus.wdata0 = '0;
        bus.we1 = 0; bus.waddr1 = '0; bus.wdata1 = '0;
        bus.re = '0; bus.raddr = '0;
        bus.issue_vld = 0; bus.issue_addr = '0;
    endtask

    task automatic set_rd(input int k, input int addr, input bit en);
        bus.raddr[k*AW +: AW] = AW'(addr);
        bus.re[k] = en;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_busy[i] = 0;
        end
    endtask

    function automatic logic [DW-1:0] exp_rdata(input int k);
        int a;
        a = int'(bus.raddr[k*AW +: AW]);
        if (!bus.re[k] || a == 0) return '0;
        if (bus.we1 && int'(bus.waddr1) == a) return bus.wdata1;
        if (bus.we0 && int'(bus.waddr0) == a) return bus.wdata0;
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(input int k);
        int a;
        a = int'(bus.raddr[k*AW +: AW]);
        if (!bus.re[k] || a == 0) return 0;
        if (bus.we1 && int'(bus.waddr1) == a) return 0;
        if (bus.we0 && int'(bus.waddr0) == a) return 0;
        return m_busy[a];
    endfunction

    // Apply this cycle's requests to the model, then advance one clock.
    task automatic tick();
        if (bus.we0 && bus.waddr0 != 0) begin
            m_mem[bus.waddr0] = bus.wdata0;
            m_busy[bus.waddr0] = 0;
        end
        if (bus.we1 && bus.waddr1 != 0) begin
            m_mem[bus.waddr1] = bus.wdata1;
            m_busy[bus.waddr1] = 0;
        end
        if (bus.issue_vld && bus.issue_addr != 0) m_busy[bus.issue_addr] = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        idle();
        rst = 1;
        @(posedge clk); #1;
        checks++;
        if (bus.init_done !== 1'b0 || bus.rdata !== '0 || bus.busy !== '0) begin
            errors++;
            $display("FAIL reset_state init_done=%b rdata=%h busy=%b want 0/0/0",
                     bus.init_done, bus.rdata, bus.busy);
        end
        rst = 0;
        n = 0;
        while (n < 40) begin
            bus.we0 = 1; bus.waddr0 = AW'($urandom); bus.wdata0 = $urandom;
            bus.we1 = 1; bus.waddr1 = AW'($urandom); bus.wdata1 = $urandom;
            bus.issue_vld = 1; bus.issue_addr = AW'($urandom);
            set_rd(0, $urandom_range(1, 31), 1);
            set_rd(1, $urandom_range(1, 31), 1);
            #1;
            checks++;
            if (bus.rdata !== '0 || bus.busy !== '0) begin
                errors++;
                $display("FAIL init_quiet cyc=%0d rdata=%h busy=%b want 0/0", n, bus.rdata, bus.busy);
            end
            @(posedge clk); #1;
            n++;
            if (bus.init_done) break;
        end
        idle();
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL init_len got=%0d want=%0d", n, DEPTH);
        end
        model_clear();
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(0, a, 1);
            set_rd(1, DEPTH - 1 - a, 1);
            #1;
            checks++;
            if (bus.rdata !== '0 || bus.busy !== '0) begin
                errors++;
                $display("FAIL clear_read addr=%0d rdata=%h busy=%b want 0", a, bus.rdata, bus.busy);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_bypass();
        idle();
        bus.we0 = 1; bus.waddr0 = 5; bus.wdata0 = 32'hDEADBEEF;
        set_rd(0, 5, 1);
        #1;
        checks++;
        if (bus.rdata[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass got=%h want=deadbeef", bus.rdata[31:0]);
        end
        tick();
        bus.we0 = 0;
        #1;
        checks++;
        if (bus.rdata[31:0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL stored got=%h want=deadbeef", bus.rdata[31:0]);
        end
        idle();
    endtask

    task automatic test_same_addr();
        idle();
        bus.we0 = 1; bus.waddr0 = 7; bus.wdata0 = 32'h11;
        bus.we1 = 1; bus.waddr1 = 7; bus.wdata1 = 32'h22;
        set_rd(1, 7, 1);
        #1;
        checks++;
        if (bus.rdata[63:32] !== 32'h22) begin
            errors++;
            $display("FAIL dual_bypass got=%h want=22", bus.rdata[63:32]);
        end
        tick();
        idle();
        bus.we1 = 1; bus.waddr1 = 0; bus.wdata1 = 32'h55;
        tick();
        idle();
        set_rd(0, 7, 1);
        set_rd(1, 0, 1);
        #1;
        checks++;
        if (bus.rdata[31:0] !== 32'h22 || bus.rdata[63:32] !== '0) begin
            errors++;
            $display("FAIL dual_store got7=%h got0=%h want 22/0", bus.rdata[31:0], bus.rdata[63:32]);
        end
        idle();
    endtask

    task automatic test_scoreboard();
        idle();
        bus.issue_vld = 1; bus.issue_addr = 3;
        set_rd(0, 3, 1);
        #1;
        checks++;
        if (bus.busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL sb_issue_cycle got=%b want=0", bus.busy[0]);
        end
        tick();
        bus.issue_vld = 0;
        #1;
        checks++;
        if (bus.busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL sb_set got=%b want=1", bus.busy[0]);
        end
        bus.we1 = 1; bus.waddr1 = 3; bus.wdata1 = 32'h3333;
        #1;
        checks++;
        if (bus.busy[0] !== 1'b0 || bus.rdata[31:0] !== 32'h3333) begin
            errors++;
            $display("FAIL sb_wb_cycle busy=%b data=%h want 0/3333", bus.busy[0], bus.rdata[31:0]);
        end
        tick();
        bus.we1 = 0;
        #1;
        checks++;
        if (bus.busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL sb_cleared got=%b want=0", bus.busy[0]);
        end
        bus.issue_vld = 1; bus.issue_addr = 3;
        bus.we0 = 1; bus.waddr0 = 3; bus.wdata0 = 32'h4444;
        tick();
        bus.issue_vld = 0; bus.we0 = 0;
        #1;
        checks++;
        if (bus.busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL sb_issue_wins got=%b want=1", bus.busy[0]);
        end
        bus.issue_vld = 1; bus.issue_addr = 0;
        set_rd(1, 0, 1);
        tick();
        bus.issue_vld = 0;
        #1;
        checks++;
        if (bus.busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL sb_addr0 got=%b want=0", bus.busy[1]);
        end
        idle();
    endtask

    task automatic test_read_disable();
        idle();
        bus.we0 = 1; bus.waddr0 = 9; bus.wdata0 = 32'hAA;
        bus.issue_vld = 1; bus.issue_addr = 9;
        tick();
        idle();
        set_rd(0, 9, 1);
        set_rd(1, 9, 0);
        #1;
        checks++;
        if (bus.rdata[63:32] !== '0 || bus.busy[1] !== 1'b0 ||
            bus.rdata[31:0] !== 32'hAA || bus.busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL re_off rdata=%h busy=%b want 00000000000000aa/01", bus.rdata, bus.busy);
        end
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.we0 = 1'($urandom); bus.waddr0 = AW'($urandom_range(0, 7));
            bus.wdata0 = $urandom;
            bus.we1 = 1'($urandom); bus.waddr1 = AW'($urandom_range(0, 7));
            bus.wdata1 = $urandom;
            bus.issue_vld = ($urandom_range(0, 2) == 0);
            bus.issue_addr = AW'($urandom_range(0, 7));
            for (int k = 0; k < NRD; k++) begin
                set_rd(k, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7),
                       $urandom_range(0, 3) != 0);
            end
            #1;
            for (int k = 0; k < NRD; k++) begin
                checks++;
                if (bus.rdata[k*DW +: DW] !== exp_rdata(k) || bus.busy[k] !== exp_busy(k)) begin
                    errors++;
                    $display("FAIL random c=%0d port=%0d data=%h busy=%b want %h/%b", c, k,
                             bus.rdata[k*DW +: DW], bus.busy[k], exp_rdata(k), exp_busy(k));
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid_init();
        int n;
        idle();
        bus.we0 = 1; bus.waddr0 = 9; bus.wdata0 = 32'hAA;
        bus.issue_vld = 1; bus.issue_addr = 10;
        tick();
        idle();
        set_rd(0, 9, 1);
        set_rd(1, 10, 1);
        rst = 1;
        bus.we1 = 1; bus.waddr1 = 11; bus.wdata1 = 32'hBB;
        #1;
        checks++;
        if (bus.rdata !== '0 || bus.busy !== '0) begin
            errors++;
            $display("FAIL rst_in_run rdata=%h busy=%b want 0/0", bus.rdata, bus.busy);
        end
        @(posedge clk); #1;
        rst = 0;
        bus.we1 = 0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (bus.init_done) break;
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL restart_len got=%0d want=%0d", n, DEPTH);
        end
        model_clear();
        set_rd(0, 9, 1);
        set_rd(1, 11, 1);
        #1;
        checks++;
        if (bus.rdata !== '0 || bus.busy !== '0) begin
            errors++;
            $display("FAIL restart_clear rdata=%h busy=%b want 0/0", bus.rdata, bus.busy);
        end
        idle();
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_bypass();
        test_same_addr();
        test_scoreboard();
        test_read_disable();
        test_reset_mid_init();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
